// File: rtl/lvda_sampler_pkg.sv
// lvda_sampler_pkg: shared readout states, sizing helpers and reset constants for id_sampler_gen
package lvda_sampler_pkg;

   typedef enum logic [1:0] {RD_IDLE, RD_SHIFT, RD_DONE} rd_state_e;

   localparam logic DM_RST = 1'b0;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int frame_len(input int channels, input bit parity);
      return channels + (parity ? 1 : 0);
   endfunction

endpackage

// File: rtl/dm_latch_cell.sv
// dm_latch_cell: one DM set/clear latch; supply loss beats clear, clear beats set
module dm_latch_cell
   import lvda_sampler_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic v1,
   input  logic clr,
   input  logic set_c,
   output logic dm,
   output logic dmn,
   output logic dm_nxt
);

   logic dm_q, dm_d;

   // next latch value by priority: no supply, clear, set, hold
   always_comb dm_d = ~v1 ? 1'b0 : clr ? 1'b0 : set_c ? 1'b1 : dm_q;

   // latch register
   always_ff @(posedge clk) dm_q <= rst ? DM_RST : dm_d;

   assign dm     = dm_q;
   assign dmn    = ~dm_q;
   assign dm_nxt = dm_d;

endmodule

// File: rtl/id_sampler_gen.sv
// id_sampler_gen: DM latch bank with serial snapshot readout; ID_SAMPLER_PARITY_EN appends an odd-parity bit
module id_sampler_gen
   import lvda_sampler_pkg::*;
#(
   parameter int CHANNELS     = 4,
   parameter int GROUPS       = 9,
   parameter bit RD_LSB_FIRST = 1'b1
) (
   input  logic                         SIM_CLK,
   input  logic                         SIM_RST,
   input  logic                         V1,
   input  logic [GROUPS-1:0]            GRP_EN,
   input  logic [GROUPS-1:0]            GRP_STB,
   input  logic [GROUPS*CHANNELS-1:0]   SRC_N,
   input  logic                         CLR_REQ,
   input  logic                         CLR_STB,
   input  logic                         CLR_QUAL,
   input  logic                         RD_REQ,
   output logic [CHANNELS-1:0]          DM,
   output logic [CHANNELS-1:0]          DMN,
   output logic                         RD_BUSY,
   output logic                         RD_DATA,
   output logic                         RD_VALID,
   output logic                         RD_LAST
);

`ifdef ID_SAMPLER_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   localparam int FRAME = frame_len(CHANNELS, PAR);
   localparam int CW    = clog2(FRAME + 1);
   localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

   logic [GROUPS:0][CHANNELS-1:0] acc;
   logic [CHANNELS-1:0] set_c, dm_nxt, ord, sh;
   logic [CHANNELS-1:0] snap_q, snap_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   rd_state_e           state_q, state_d;
   logic                clr, bit_sel;

   assign clr    = CLR_REQ & CLR_STB & CLR_QUAL;
   assign acc[0] = '0;

   for (genvar g = 0; g < GROUPS; g++) begin : g_grp
      assign acc[g+1] = acc[g] | ({CHANNELS{GRP_EN[g] & GRP_STB[g]}} & ~SRC_N[g*CHANNELS +: CHANNELS]);
   end

   assign set_c = acc[GROUPS];

   for (genvar c = 0; c < CHANNELS; c++) begin : g_cell
      dm_latch_cell u_cell (
         .clk    (SIM_CLK),
         .rst    (SIM_RST),
         .v1     (V1),
         .clr    (clr),
         .set_c  (set_c[c]),
         .dm     (DM[c]),
         .dmn    (DMN[c]),
         .dm_nxt (dm_nxt[c])
      );
   end

   // readout sequencing: snapshot the post-edge DM on request, shift FRAME bits, one idle-busy cycle
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      snap_d  = snap_q;
      case (state_q)
         RD_IDLE: begin
            state_d = RD_REQ ? RD_SHIFT : RD_IDLE;
            cnt_d   = '0;
            snap_d  = RD_REQ ? dm_nxt : snap_q;
         end
         RD_SHIFT: begin
            cnt_d   = cnt_q + CW'(1);
            state_d = (cnt_q == LAST) ? RD_DONE : RD_SHIFT;
         end
         RD_DONE: begin
            cnt_d   = '0;
            state_d = RD_IDLE;
         end
         default: state_d = RD_IDLE;
      endcase
   end

   // readout state, counter and snapshot registers
   always_ff @(posedge SIM_CLK) begin
      if (SIM_RST) begin
         state_q <= RD_IDLE;
         cnt_q   <= '0;
         snap_q  <= {CHANNELS{DM_RST}};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         snap_q  <= snap_d;
      end
   end

   assign ord = RD_LSB_FIRST ? snap_q : {<<{snap_q}};
   assign sh  = ord >> cnt_q;

`ifdef ID_SAMPLER_PARITY_EN
   assign bit_sel = (cnt_q == CW'(CHANNELS)) ? ~^snap_q : sh[0];
`else
   assign bit_sel = sh[0];
`endif

   assign RD_BUSY  = state_q != RD_IDLE;
   assign RD_VALID = state_q == RD_SHIFT;
   assign RD_DATA  = RD_VALID & bit_sel;
   assign RD_LAST  = RD_VALID & (cnt_q == LAST);

endmodule
